// File: rtl/capture_ring_buf_pkg.sv
// capture_ring_buf_pkg: shared capture FSM states and mode encodings.
// Revision 1.0
`default_nettype none

package capture_ring_buf_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    WAIT = 3'd2,
    POST = 3'd3,
    DONE = 3'd4
  } cap_state_t;

  localparam logic CAP_MODE_ONESHOT = 1'b0;
  localparam logic CAP_MODE_RING    = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sdp_bram_reg2.sv
// sdp_bram_reg2: simple dual-port RAM, port A write / port B read-first, 2-cycle read.
// Revision 1.0
`default_nettype none

module sdp_bram_reg2 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] rdata_q;
  logic              re_q;
  logic              rvalid_q;

  // Storage and RAM output register carry no reset so they map onto block RAM;
  // read-first falls out of both accesses being non-blocking on the same edge.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      ram_q <= mem_q[raddr_i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      re_q     <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      re_q     <= re_i;
      rvalid_q <= re_q;
      if (re_q) begin
        rdata_q <= ram_q;
      end
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;

endmodule

`default_nettype wire

// File: rtl/capture_ring_buf.sv
// capture_ring_buf: armed/triggered sample capture into a BRAM ring with registered readout.
// Revision 1.0
`default_nettype none

module capture_ring_buf
  import capture_ring_buf_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int CHAN_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm_i,
  input  logic              trig_i,
  input  logic              mode_i,
  input  logic [ADDR_W-1:0] pretrig_len_i,
  input  logic [CHAN_W-1:0] chan_sel_i,
  input  logic              chan_all_i,
  input  logic              in_valid_i,
  input  logic [CHAN_W-1:0] in_chan_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W:0]   wr_count_o,
  output logic [ADDR_W-1:0] trig_addr_o
);

  localparam logic [ADDR_W:0]   DEPTH_V = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_W1  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE_A   = {{(ADDR_W-1){1'b0}}, 1'b1};

  cap_state_t        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   wr_count_q, wr_count_d;
  logic [ADDR_W:0]   post_left_q, post_left_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] plen_q, plen_d;
  logic              mode_q, mode_d;

  logic              qual;
  logic [ADDR_W:0]   qual_w1;
  logic              we;

  assign qual    = in_valid_i & (chan_all_i | (in_chan_i == chan_sel_i));
  assign qual_w1 = {{ADDR_W{1'b0}}, qual};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      wr_count_q  <= '0;
      post_left_q <= '0;
      trig_addr_q <= '0;
      plen_q      <= '0;
      mode_q      <= CAP_MODE_ONESHOT;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_count_q  <= wr_count_d;
      post_left_q <= post_left_d;
      trig_addr_q <= trig_addr_d;
      plen_q      <= plen_d;
      mode_q      <= mode_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_count_d  = wr_count_q;
    post_left_d = post_left_q;
    trig_addr_d = trig_addr_q;
    plen_d      = plen_q;
    mode_d      = mode_q;
    we          = 1'b0;

    if (arm_i) begin
      // pretrig_len is ADDR_W bits, so it can never exceed DEPTH-1.
      wr_ptr_d   = '0;
      wr_count_d = '0;
      mode_d     = mode_i;
      plen_d     = pretrig_len_i;
      state_d    = (mode_i == CAP_MODE_RING) ? PRE : WAIT;
    end else begin
      case (state_q)
        PRE: begin
          we = qual;
          if (trig_i && (wr_count_q >= {1'b0, plen_q})) begin
            trig_addr_d = wr_ptr_q;
            post_left_d = DEPTH_V - {1'b0, plen_q} - qual_w1;
            state_d     = (post_left_d == '0) ? DONE : POST;
          end
        end
        WAIT: begin
          if (trig_i) begin
            we          = qual;
            trig_addr_d = '0;
            post_left_d = DEPTH_V - qual_w1;
            state_d     = POST;
          end
        end
        POST: begin
          we = qual;
          if (qual) begin
            post_left_d = post_left_q - ONE_W1;
            if (post_left_q == ONE_W1) begin
              state_d = DONE;
            end
          end
        end
        default: begin
        end
      endcase

      if (we) begin
        wr_ptr_d = wr_ptr_q + ONE_A;
        if (wr_count_q != DEPTH_V) begin
          wr_count_d = wr_count_q + ONE_W1;
        end
      end
    end
  end

  sdp_bram_reg2 #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .we_i     (we),
    .waddr_i  (wr_ptr_q),
    .wdata_i  (in_data_i),
    .re_i     (rd_en_i),
    .raddr_i  (rd_addr_i),
    .rdata_o  (rd_data_o),
    .rvalid_o (rd_valid_o)
  );

  assign busy_o      = (state_q == PRE) || (state_q == WAIT) || (state_q == POST);
  assign done_o      = (state_q == DONE);
  assign wr_count_o  = wr_count_q;
  assign trig_addr_o = trig_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_capture_ring_buf.sv
// tb_capture_ring_buf: directed capture scenarios with a read-response scoreboard.
// Revision 1.0
`default_nettype none

module tb_capture_ring_buf;

  logic        clk;
  logic        rst;
  logic        arm, trig, mode, chan_all, in_valid, rd_en;
  logic [3:0]  pretrig_len, rd_addr;
  logic [7:0]  chan_sel, in_chan;
  logic [31:0] in_data;
  logic [31:0] rd_data;
  logic        rd_valid, busy, done;
  logic [4:0]  wr_count;
  logic [3:0]  trig_addr;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  capture_ring_buf #(.DATA_W(32), .ADDR_W(4), .CHAN_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .arm_i        (arm),
    .trig_i       (trig),
    .mode_i       (mode),
    .pretrig_len_i(pretrig_len),
    .chan_sel_i   (chan_sel),
    .chan_all_i   (chan_all),
    .in_valid_i   (in_valid),
    .in_chan_i    (in_chan),
    .in_data_i    (in_data),
    .rd_en_i      (rd_en),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .rd_valid_o   (rd_valid),
    .busy_o       (busy),
    .done_o       (done),
    .wr_count_o   (wr_count),
    .trig_addr_o  (trig_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Read-response monitor: every rd_valid must match the oldest outstanding read,
  // both in data and in the cycle it arrives.
  always @(negedge clk) begin
    if (rd_valid) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got rd_valid=1 data=%0d required no read outstanding", rd_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (rd_data !== mon_e.data || cyc != mon_e.due) begin
          n_fail++;
          $display("FAIL rd_data: got %0d at cycle %0d required %0d at cycle %0d",
                   rd_data, cyc, mon_e.data, mon_e.due);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    arm = 1'b0; trig = 1'b0; in_valid = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_arm(input logic m, input logic [3:0] pl);
    arm = 1'b1; mode = m; pretrig_len = pl;
    step();
  endtask

  task automatic do_trig();
    trig = 1'b1;
    step();
  endtask

  task automatic sample(input logic [7:0] ch, input logic [31:0] d, input logic t);
    in_valid = 1'b1; in_chan = ch; in_data = d; trig = t;
    step();
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    rd_en = 1'b1; rd_addr = a;
    exp_q.push_back('{e, cyc + 2});
    step();
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 20) begin
      step();
      b++;
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rd_timeout: got %0d reads outstanding required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    arm = 0; trig = 0; mode = 0; chan_all = 1; in_valid = 0; rd_en = 0;
    pretrig_len = '0; rd_addr = '0; chan_sel = '0; in_chan = '0; in_data = '0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_trig_addr", trig_addr, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    step();

    // T1 one-shot
    do_arm(1'b0, 4'd0);
    check("t1_busy_wait", busy, 1);
    sample(8'd0, 32'd99, 1'b0);
    check("t1_wait_no_write", wr_count, 0);
    do_trig();
    for (int i = 0; i < 16; i++) begin
      sample(8'd0, i, 1'b0);
      if (i == 14) check("t1_done_early", done, 0);
    end
    check("t1_done", done, 1);
    check("t1_busy_end", busy, 0);
    check("t1_trig_addr", trig_addr, 0);
    check("t1_wr_count", wr_count, 16);
    sample(8'd0, 32'd77, 1'b0);
    for (int i = 0; i < 16; i++) rd(i[3:0], i);
    drain();

    // T2 pre-trigger ring
    do_arm(1'b1, 4'd4);
    for (int i = 0; i < 10; i++) sample(8'd1, i, 1'b0);
    sample(8'd1, 32'd10, 1'b1);
    check("t2_trig_addr", trig_addr, 10);
    for (int i = 11; i < 22; i++) begin
      sample(8'd1, i, 1'b0);
      if (i == 20) check("t2_done_early", done, 0);
    end
    check("t2_done", done, 1);
    check("t2_wr_count", wr_count, 16);
    for (int i = 6; i < 16; i++) rd(i[3:0], i);
    for (int i = 0; i < 6; i++) rd(i[3:0], 16 + i);
    drain();

    // T3 channel filter
    chan_sel = 8'd3; chan_all = 1'b0;
    do_arm(1'b0, 4'd0);
    do_trig();
    for (int i = 0; i < 32; i++) sample(i % 8, 100 + i, 1'b0);
    check("t3_filt_count", wr_count, 4);
    check("t3_filt_done", done, 0);
    for (int i = 0; i < 4; i++) rd(i[3:0], 103 + 8 * i);
    drain();
    chan_all = 1'b1;
    do_arm(1'b0, 4'd0);
    do_trig();
    for (int i = 0; i < 8; i++) sample(i % 8, 200 + i, 1'b0);
    check("t3_all_count", wr_count, 8);
    for (int i = 0; i < 8; i++) rd(i[3:0], 200 + i);
    drain();

    // T4 early trigger ignored
    do_arm(1'b1, 4'd8);
    for (int i = 0; i < 3; i++) sample(8'd2, 300 + i, 1'b0);
    do_trig();
    check("t4_busy", busy, 1);
    check("t4_count3", wr_count, 3);
    for (int i = 3; i < 8; i++) sample(8'd2, 300 + i, 1'b0);
    check("t4_count8", wr_count, 8);
    do_trig();
    check("t4_trig_addr", trig_addr, 8);
    for (int i = 8; i < 16; i++) begin
      sample(8'd2, 300 + i, 1'b0);
      if (i == 14) check("t4_done_early", done, 0);
    end
    check("t4_done", done, 1);
    check("t4_wr_count", wr_count, 16);
    rd(4'd0, 300);
    rd(4'd8, 308);
    drain();

    // T5 re-arm during POST, arm+trig together
    do_arm(1'b0, 4'd0);
    do_trig();
    for (int i = 0; i < 5; i++) sample(8'd0, 400 + i, 1'b0);
    check("t5_post_count", wr_count, 5);
    do_arm(1'b1, 4'd2);
    check("t5_rearm_count", wr_count, 0);
    check("t5_rearm_busy", busy, 1);
    sample(8'd0, 32'd440, 1'b0);
    check("t5_pre_writes", wr_count, 1);
    trig = 1'b1;
    do_arm(1'b0, 4'd0);
    check("t5_armtrig_count", wr_count, 0);
    sample(8'd0, 32'd450, 1'b0);
    check("t5_armtrig_wait", wr_count, 0);
    do_trig();
    sample(8'd0, 32'd451, 1'b0);
    check("t5_post_after", wr_count, 1);

    // T6 reset mid-POST with a read in flight
    do_arm(1'b0, 4'd0);
    do_trig();
    for (int i = 0; i < 3; i++) sample(8'd0, 600 + i, 1'b0);
    rd_en = 1'b1; rd_addr = 4'd0;
    step();
    rst = 1'b1;
    step();
    step();
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_wr_count", wr_count, 0);
    check("t6_rd_valid", rd_valid, 0);
    rst = 1'b0;
    step();
    do_arm(1'b0, 4'd0);
    do_trig();
    for (int i = 0; i < 16; i++) sample(8'd0, 500 + i, 1'b0);
    check("t6_done_after", done, 1);
    rd(4'd15, 515);
    rd(4'd0, 500);
    drain();

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
